// File: rtl/spw_rx_pkg.sv
// Shared types and constants for the SpaceWire receive character decoder:
// character types, control codes, framing lengths and the FIFO entry layout.
package spw_rx_pkg;

    typedef enum logic [2:0] {
        CH_DATA = 3'd0,
        CH_EOP  = 3'd1,
        CH_EEP  = 3'd2,
        CH_FCT  = 3'd3,
        CH_NULL = 3'd4,
        CH_TIME = 3'd5
    } char_type_t;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } rx_state_t;

    localparam logic [1:0] CTL_FCT = 2'b00;
    localparam logic [1:0] CTL_EOP = 2'b01;
    localparam logic [1:0] CTL_EEP = 2'b10;
    localparam logic [1:0] CTL_ESC = 2'b11;

    localparam logic [3:0] CTRL_LEN = 4'd4;
    localparam logic [3:0] DATA_LEN = 4'd10;

    // Last seven bits of a NULL in arrival order: ESC flag/ctl, FCT P, flag, ctl.
    localparam logic [6:0] NULL_PATTERN = 7'b1110100;

    typedef struct packed {
        char_type_t  ctype;
        logic [7:0]  data;
    } fifo_entry_t;

    // Odd parity covers the previous payload plus the current flag bit.
    function automatic logic parity_gen(input logic flag, input logic prev_xor);
        return ~(flag ^ prev_xor);
    endfunction

endpackage

// File: rtl/spw_rx_char_fifo.sv
// Small ready/valid FIFO of decoded characters. A push while full is accepted
// only when a pop happens in the same cycle.
module spw_rx_char_fifo
    import spw_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  fifo_entry_t            push_entry,
    input  logic                   pop,
    output fifo_entry_t            head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    fifo_entry_t   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign level     = count_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, power-of-two wrapping pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spw_rx_char_decoder.sv
// SpaceWire receive character decoder: NULL hunt, character framing, parity,
// ESC folding and output FIFO. Define SPW_RX_TIMECODE_EN to decode ESC+data as TIME.
module spw_rx_char_decoder
    import spw_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STRIP_NULL = 1
) (
    input  logic                        posedge_clk,
    input  logic                        rx_reset,
    input  logic                        bit_valid,
    input  logic                        bit_in,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [2:0]                  out_type,
    output logic [7:0]                  out_data,
    output logic                        got_null,
    output logic                        err_parity,
    output logic                        err_esc,
    output logic                        err_ovf,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    rx_state_t   state_r, state_s;
    logic [6:0]  window_r, window_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        p_r, p_s;
    logic        f_r, f_s;
    logic [7:0]  payload_r, payload_s;
    logic        prev_xor_r, prev_xor_s;
    logic        esc_pend_r, esc_pend_s;
    logic        got_null_r, got_null_s;
    logic        err_parity_r, err_parity_s;
    logic        err_esc_r, err_esc_s;
    logic        err_ovf_r, err_ovf_s;

    logic        push_req_s;
    logic        push_s;
    logic        ovf_s;
    logic        pop_s;
    logic        full_s;
    logic        empty_s;
    fifo_entry_t push_entry_s;
    fifo_entry_t head_s;
    logic [3:0]  char_len_s;
    logic        last_s;
    logic [7:0]  payload_full_s;

    assign pop_s          = !empty_s && out_ready;
    assign char_len_s     = f_r ? CTRL_LEN : DATA_LEN;
    assign last_s         = (cnt_r >= 4'd2) && (cnt_r == (char_len_s - 4'd1));
    assign payload_full_s = payload_r | ({7'd0, bit_in} << (cnt_r - 4'd2));

    // State register and sticky status flags.
    always_ff @(posedge posedge_clk) begin
        if (rx_reset) begin
            state_r      <= ST_HUNT;
            window_r     <= 7'd0;
            cnt_r        <= 4'd0;
            p_r          <= 1'b0;
            f_r          <= 1'b0;
            payload_r    <= 8'd0;
            prev_xor_r   <= 1'b0;
            esc_pend_r   <= 1'b0;
            got_null_r   <= 1'b0;
            err_parity_r <= 1'b0;
            err_esc_r    <= 1'b0;
            err_ovf_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            window_r     <= window_s;
            cnt_r        <= cnt_s;
            p_r          <= p_s;
            f_r          <= f_s;
            payload_r    <= payload_s;
            prev_xor_r   <= prev_xor_s;
            esc_pend_r   <= esc_pend_s;
            got_null_r   <= got_null_s;
            err_parity_r <= err_parity_s;
            err_esc_r    <= err_esc_s;
            err_ovf_r    <= err_ovf_s;
        end
    end

    // Hunt, framing, parity and ESC decode; the push request is resolved
    // against FIFO fullness at the end.
    always_comb begin
        state_s      = state_r;
        window_s     = window_r;
        cnt_s        = cnt_r;
        p_s          = p_r;
        f_s          = f_r;
        payload_s    = payload_r;
        prev_xor_s   = prev_xor_r;
        esc_pend_s   = esc_pend_r;
        got_null_s   = got_null_r;
        err_parity_s = err_parity_r;
        err_esc_s    = err_esc_r;
        err_ovf_s    = err_ovf_r;
        push_req_s   = 1'b0;
        push_entry_s = '{ctype: CH_FCT, data: 8'd0};

        case (state_r)
            ST_HUNT: begin
                if (bit_valid) begin
                    window_s = {window_r[5:0], bit_in};
                    if (window_s == NULL_PATTERN) begin
                        got_null_s = 1'b1;
                        prev_xor_s = 1'b0;
                        esc_pend_s = 1'b0;
                        cnt_s      = 4'd0;
                        state_s    = ST_RUN;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end else begin
                    state_s = ST_HUNT;
                end
            end
            ST_RUN: begin
                if (!bit_valid) begin
                    state_s = ST_RUN;
                end else if (cnt_r == 4'd0) begin
                    p_s       = bit_in;
                    payload_s = 8'd0;
                    cnt_s     = 4'd1;
                end else if (cnt_r == 4'd1) begin
                    f_s   = bit_in;
                    cnt_s = 4'd2;
                end else if (!last_s) begin
                    payload_s = payload_full_s;
                    cnt_s     = cnt_r + 4'd1;
                end else begin
                    payload_s = payload_full_s;
                    cnt_s     = 4'd0;
                    if (p_r != parity_gen(f_r, prev_xor_r)) begin
                        err_parity_s = 1'b1;
                        state_s      = ST_ERR;
                    end else begin
                        prev_xor_s = ^payload_full_s;
                        esc_pend_s = 1'b0;
                        if (f_r) begin
                            case (payload_full_s[1:0])
                                CTL_ESC: begin
                                    if (esc_pend_r) begin
                                        err_esc_s = 1'b1;
                                        state_s   = ST_ERR;
                                    end else begin
                                        esc_pend_s = 1'b1;
                                    end
                                end
                                CTL_FCT: begin
                                    if (esc_pend_r) begin
                                        push_req_s   = (STRIP_NULL == 0);
                                        push_entry_s = '{ctype: CH_NULL, data: 8'd0};
                                    end else begin
                                        push_req_s   = 1'b1;
                                        push_entry_s = '{ctype: CH_FCT, data: 8'd0};
                                    end
                                end
                                CTL_EOP: begin
                                    if (esc_pend_r) begin
                                        err_esc_s = 1'b1;
                                        state_s   = ST_ERR;
                                    end else begin
                                        push_req_s   = 1'b1;
                                        push_entry_s = '{ctype: CH_EOP, data: 8'd0};
                                    end
                                end
                                CTL_EEP: begin
                                    if (esc_pend_r) begin
                                        err_esc_s = 1'b1;
                                        state_s   = ST_ERR;
                                    end else begin
                                        push_req_s   = 1'b1;
                                        push_entry_s = '{ctype: CH_EEP, data: 8'd0};
                                    end
                                end
                                default: begin
                                    state_s = ST_ERR;
                                end
                            endcase
                        end else if (esc_pend_r) begin
`ifdef SPW_RX_TIMECODE_EN
                            push_req_s   = 1'b1;
                            push_entry_s = '{ctype: CH_TIME, data: payload_full_s};
`else
                            err_esc_s = 1'b1;
                            state_s   = ST_ERR;
`endif
                        end else begin
                            push_req_s   = 1'b1;
                            push_entry_s = '{ctype: CH_DATA, data: payload_full_s};
                        end
                    end
                end
            end
            ST_ERR: begin
                state_s = ST_ERR;
            end
            default: begin
                state_s = ST_HUNT;
            end
        endcase

        ovf_s = push_req_s && full_s && !pop_s;
        if (ovf_s) begin
            err_ovf_s = 1'b1;
            state_s   = ST_ERR;
        end else begin
            err_ovf_s = err_ovf_s;
        end
        push_s = push_req_s && !ovf_s;
    end

    spw_rx_char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (posedge_clk),
        .rst        (rx_reset),
        .push       (push_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .head       (head_s),
        .full       (full_s),
        .empty      (empty_s),
        .level      (fifo_level)
    );

    assign out_valid  = !empty_s;
    assign out_type   = head_s.ctype;
    assign out_data   = head_s.data;
    assign got_null   = got_null_r;
    assign err_parity = err_parity_r;
    assign err_esc    = err_esc_r;
    assign err_ovf    = err_ovf_r;

endmodule
